// File: rtl/debounce_pkg.sv
// Shared defaults for the push-button debouncer, so RTL and benches agree
// on one set of constants.
package debounce_pkg;

    localparam int DB_CHANNELS       = 4;
    localparam int DB_STABLE_SAMPLES = 10;
    localparam int DB_SYNC_STAGES    = 2;

    // Counter width able to hold 0..samples.
    function automatic int cnt_width(input int samples);
        return $clog2(samples + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: synchroniser, tick-driven stability counter, and
// registered level plus one-clock rise/fall pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_SAMPLES = DB_STABLE_SAMPLES,
    parameter int SYNC_STAGES    = DB_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam int              CW   = cnt_width(STABLE_SAMPLES);
    localparam logic [CW-1:0]   LAST = CW'(STABLE_SAMPLES - 1);

    if (STABLE_SAMPLES < 1) begin : g_bad_samples
        $error("debounce_channel: STABLE_SAMPLES must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_channel: SYNC_STAGES must be >= 2");
    end

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            db   <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            // NOTE: pulses are cleared on every edge and only set on a toggle,
            // which keeps them one clock wide even with tick held high.
            rise <= 1'b0;
            fall <= 1'b0;
            if (tick) begin
                if (s == db) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    db   <= s;
                    cnt  <= '0;
                    rise <= s;
                    fall <= ~s;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button debouncer: CHANNELS independent debounce_channel
// instances sharing one sample tick.
module btn_debounce_multi
    import debounce_pkg::*;
#(
    parameter int CHANNELS       = DB_CHANNELS,
    parameter int STABLE_SAMPLES = DB_STABLE_SAMPLES,
    parameter int SYNC_STAGES    = DB_SYNC_STAGES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] db,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("btn_debounce_multi: CHANNELS must be >= 1");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .tick  (tick),
            .btn   (btn_in[i]),
            .db    (db[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

endmodule

// File: doc/btn_debounce_multi.md
# btn_debounce_multi

Parametrised multi-channel push-button debouncer that replaces the fixed 10-tap shift-register debouncer. Each channel synchronises a raw button input, integrates it over a configurable number of sample ticks, and debounces both press and release. It produces a clean level plus one-cycle rise/fall pulses, so downstream counter and segment-load logic needs no separate edge detector. It sits between the board button pins and the control FSMs, fed by the shared sample-tick generator.

## Interface
- CHANNELS, 4, number of independent button channels (>= 1)
- STABLE_SAMPLES, 10, consecutive differing ticks required before the debounced level changes (>= 1)
- SYNC_STAGES, 2, synchroniser flop depth per channel (>= 2)

- clk  input  1  system clock; all state on posedge clk
- reset  input  1  asynchronous, active-high; clears all state
- tick  input  1  sample enable, one clk cycle wide, from the shared pulse generator (1 or 10 ms)
- btn_in  input  CHANNELS  raw asynchronous button levels, bit i = channel i
- db  output  CHANNELS  debounced level per channel, registered
- rise  output  CHANNELS  one-cycle pulse when db[i] goes 0->1, registered
- fall  output  CHANNELS  one-cycle pulse when db[i] goes 1->0, registered

## Operation
- Per channel: SYNC_STAGES-flop synchroniser on btn_in[i], clocked every clk (not gated by tick). Its output is s[i].
- Per channel: counter cnt, width $clog2(STABLE_SAMPLES+1), saturating by construction.
- On a clk edge with tick=1:
  - If s[i] == db[i]: cnt <= 0. A single agreeing sample restarts integration.
  - If s[i] != db[i] and cnt == STABLE_SAMPLES-1: db[i] <= s[i], cnt <= 0, and rise[i] or fall[i] <= 1 by direction.
  - Otherwise: cnt <= cnt + 1.
- tick=0: cnt and db hold.
- rise/fall are 0 on every edge that does not toggle db for that channel, so each is exactly one clk wide, even with tick held high.
- rise[i] and fall[i] are never both 1. Channels are fully independent; simultaneous toggles on several channels are allowed.
- STABLE_SAMPLES=1: db follows s on every tick, with no filtering.
- Parameter violations are caught by elaboration-time $error.

## Timing
- Reset values: db=0, rise=0, fall=0, cnt=0, synchroniser flops=0.
- Reset asserted mid-integration discards partial counts. After release, a held button needs a full STABLE_SAMPLES ticks.
- Latency from a clean btn_in step to the db change: SYNC_STAGES clk cycles plus STABLE_SAMPLES ticks. The db change lands on the clk edge of the STABLE_SAMPLES-th qualifying tick.
- rise/fall assert on the same edge db changes and deassert on the next edge.
- A glitch shorter than one tick period either is not sampled or resets the count on the next agreeing tick.
- Outputs are glitch-free and registered; no combinational path exists from inputs to outputs.

## Structure
- Shared package debounce_pkg holds the default parameter constants (DB_CHANNELS, DB_STABLE_SAMPLES, DB_SYNC_STAGES) so the top level and benches use one source.
- One sub-module, debounce_channel, contains the synchroniser, counter, db, rise and fall registers for one bit, with parameters STABLE_SAMPLES and SYNC_STAGES.
- btn_debounce_multi is a generate loop of CHANNELS debounce_channel instances.

## Test plan
- Reset: assert reset mid-count with btn_in=4'b1111 held -> all outputs 0 immediately. After release, db=4'b1111 exactly 10 ticks later, with rise=4'b1111 for one clk.
- Clean press, channel 0 (default parameters, tick every 8 clk): btn_in[0] 0->1 -> db[0]=1 on the 10th tick after sync. rise[0]=1 for one clk, fall stays 0.
- Bounce rejection: btn_in[2] toggles 1,1,1,0,1,1,1,1,1,1,1,1,1,1 across ticks -> count restarts at the 0. db[2] rises on the 10th consecutive 1, never earlier.
- Release debounce: db[1]=1, then btn_in[1]=0 for 9 ticks followed by 1 -> db[1] stays 1. A further 10 ticks at 0 -> db[1]=0 and fall[1] pulses once.
- tick held high continuously, STABLE_SAMPLES=3: a step input -> db changes after exactly SYNC_STAGES+3 clk. rise is one clk wide.
- Independence: channels 0 and 3 press on the same tick, channel 1 bounces -> db[0] and db[3] rise together with rise=4'b1001, and db[1] is unaffected.
